// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, opcodes and the control bundle
// that the ID stage hands to EX.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned PC_W     = 10;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned IMM_W    = 16;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluOp_e;

    typedef struct packed {
        logic   regDst;
        logic   aluSrc;
        logic   memToReg;
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   branch;
        aluOp_e aluOp;
    } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one write port on the rising edge.
// Register 0 is an ordinary register; reset clears the whole array.
module register_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [REG_AW-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic [REG_AW-1:0] readAddrA,
    input  logic [REG_AW-1:0] readAddrB,
    output logic [DATA_W-1:0] readDataA_c,
    output logic [DATA_W-1:0] readDataB_c
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset wins over a simultaneous write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable) begin
            regs[writeAddr] <= writeData;
        end
    end

    assign readDataA_c = regs[readAddrA];
    assign readDataB_c = regs[readAddrB];

endmodule

// File: rtl/instruction_decode.sv
// ID stage: control decode, sign extension and register read, latched into the
// ID/EX register on the falling edge so rising-edge write-back is seen the same cycle.
module instruction_decode
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Instruction,
    input  logic [PC_W-1:0]   PCCount,
    input  logic              regWrite,
    input  logic [REG_AW-1:0] writeRegister,
    input  logic [DATA_W-1:0] writeData,
    output logic [1:0]        ALUOpOut,
    output logic              RegDstOut,
    output logic              ALUSrcOut,
    output logic              BranchOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic              MemToRegOut,
    output logic              RegWriteOut,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    output logic [DATA_W-1:0] signExtendOut,
    output logic [PC_W-1:0]   PcCountOut,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd
);

    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] immExt;
    ctrl_t             decodeCtrl;

    assign opcode = Instruction[31:26];
    assign immExt = {{(DATA_W-IMM_W){Instruction[IMM_W-1]}}, Instruction[IMM_W-1:0]};

    register_file regFileInst (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (regWrite),
        .writeAddr   (writeRegister),
        .writeData   (writeData),
        .readAddrA   (Instruction[25:21]),
        .readAddrB   (Instruction[20:16]),
        .readDataA_c (rsData),
        .readDataB_c (rtData)
    );

    // Main control; unknown opcodes become a bubble
    always_comb begin
        decodeCtrl = '0;
        decodeCtrl.aluOp = ALUOP_MEM;
        case (opcode)
            OP_RTYPE: begin
                decodeCtrl.regDst   = 1'b1;
                decodeCtrl.regWrite = 1'b1;
                decodeCtrl.aluOp    = ALUOP_RTYPE;
            end
            OP_LW: begin
                decodeCtrl.aluSrc   = 1'b1;
                decodeCtrl.memToReg = 1'b1;
                decodeCtrl.regWrite = 1'b1;
                decodeCtrl.memRead  = 1'b1;
            end
            OP_SW: begin
                decodeCtrl.aluSrc   = 1'b1;
                decodeCtrl.memWrite = 1'b1;
            end
            OP_BEQ: begin
                decodeCtrl.branch = 1'b1;
                decodeCtrl.aluOp  = ALUOP_BRANCH;
            end
            default: ;
        endcase
    end

    // ID/EX pipeline register
    always_ff @(negedge clk) begin
        if (reset) begin
            ALUOpOut      <= '0;
            RegDstOut     <= 1'b0;
            ALUSrcOut     <= 1'b0;
            BranchOut     <= 1'b0;
            MemReadOut    <= 1'b0;
            MemWriteOut   <= 1'b0;
            MemToRegOut   <= 1'b0;
            RegWriteOut   <= 1'b0;
            regA          <= '0;
            regB          <= '0;
            signExtendOut <= '0;
            PcCountOut    <= '0;
            rt            <= '0;
            rd            <= '0;
        end else begin
            ALUOpOut      <= decodeCtrl.aluOp;
            RegDstOut     <= decodeCtrl.regDst;
            ALUSrcOut     <= decodeCtrl.aluSrc;
            BranchOut     <= decodeCtrl.branch;
            MemReadOut    <= decodeCtrl.memRead;
            MemWriteOut   <= decodeCtrl.memWrite;
            MemToRegOut   <= decodeCtrl.memToReg;
            RegWriteOut   <= decodeCtrl.regWrite;
            regA          <= rsData;
            regB          <= rtData;
            signExtendOut <= immExt;
            PcCountOut    <= PCCount;
            rt            <= Instruction[20:16];
            rd            <= Instruction[15:11];
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for the ID stage: directed program plus random traffic against an
// array-based register model and a table-driven control model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [9:0]  PCCount;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [1:0]  ALUOpOut;
    logic        RegDstOut, ALUSrcOut, BranchOut, MemReadOut, MemWriteOut, MemToRegOut, RegWriteOut;
    logic [31:0] regA, regB, signExtendOut;
    logic [9:0]  PcCountOut;
    logic [4:0]  rt, rd;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk           (clk),
        .reset         (reset),
        .Instruction   (Instruction),
        .PCCount       (PCCount),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .ALUOpOut      (ALUOpOut),
        .RegDstOut     (RegDstOut),
        .ALUSrcOut     (ALUSrcOut),
        .BranchOut     (BranchOut),
        .MemReadOut    (MemReadOut),
        .MemWriteOut   (MemWriteOut),
        .MemToRegOut   (MemToRegOut),
        .RegWriteOut   (RegWriteOut),
        .regA          (regA),
        .regB          (regB),
        .signExtendOut (signExtendOut),
        .PcCountOut    (PcCountOut),
        .rt            (rt),
        .rd            (rd)
    );

    // Control table: {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    function automatic logic [8:0] expectedCtrl(input logic [5:0] op);
        if (op == 6'd0)       return 9'b1_0_0_1_0_0_0_10;
        else if (op == 6'd35) return 9'b0_1_1_1_1_0_0_00;
        else if (op == 6'd43) return 9'b0_1_0_0_0_1_0_00;
        else if (op == 6'd4)  return 9'b0_0_0_0_0_0_1_01;
        return 9'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive, let write-back land at the rising edge, sample after the falling edge
    task automatic cycle(input logic [31:0] instr, input logic [9:0] pc, input logic we,
                         input logic [4:0] wreg, input logic [31:0] wdata, input logic rst);
        int imm;
        logic [8:0] ctrlObs;
        Instruction   = instr;
        PCCount       = pc;
        regWrite      = we;
        writeRegister = wreg;
        writeData     = wdata;
        reset         = rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we) begin
            model[wreg] = wdata;
        end
        @(negedge clk);
        #1;
        ctrlObs = {RegDstOut, ALUSrcOut, MemToRegOut, RegWriteOut, MemReadOut, MemWriteOut,
                   BranchOut, ALUOpOut};
        imm = $signed(instr[15:0]);
        if (rst) begin
            check("ctrl_rst", 32'(ctrlObs), 32'd0);
            check("regA_rst", regA, 32'd0);
            check("regB_rst", regB, 32'd0);
            check("sext_rst", signExtendOut, 32'd0);
            check("pc_rst", 32'(PcCountOut), 32'd0);
            check("rt_rst", 32'(rt), 32'd0);
            check("rd_rst", 32'(rd), 32'd0);
        end else begin
            check("ctrl", 32'(ctrlObs), 32'(expectedCtrl(instr[31:26])));
            check("regA", regA, model[instr[25:21]]);
            check("regB", regB, model[instr[20:16]]);
            check("sext", signExtendOut, 32'(imm));
            check("pc", 32'(PcCountOut), 32'(pc));
            check("rt", 32'(rt), 32'(instr[20:16]));
            check("rd", 32'(rd), 32'(instr[15:11]));
        end
    endtask

    initial begin
        logic [5:0]  opTable [5];
        logic [5:0]  op;
        logic [31:0] instr;
        opTable[0] = 6'd0;
        opTable[1] = 6'd35;
        opTable[2] = 6'd43;
        opTable[3] = 6'd4;

        // Reset, then write-back program
        cycle(32'h0, 10'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle(32'h0, 10'd0, 1'b1, 5'd0,  32'd5250,     1'b0);
        cycle(32'h0, 10'd0, 1'b1, 5'd21, 32'd100,      1'b0);
        cycle(32'h0, 10'd0, 1'b1, 5'd31, 32'd10000000, 1'b0);
        cycle(32'h0, 10'd0, 1'b1, 5'd30, 32'd1111111,  1'b0);
        cycle(32'h0, 10'd0, 1'b1, 5'd1,  32'd9999,     1'b0);

        // SUB, LW, an unsupported opcode, then three BEQs
        cycle(32'h02BF0022, 10'd1, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(32'h8FE0AAAA, 10'd2, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(32'h83E0AAAA, 10'd2, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(32'h101E0010, 10'd3, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(32'h13C10010, 10'd4, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(32'h10350010, 10'd5, 1'b0, 5'd0, 32'd0, 1'b0);
        check("sub_r21", 32'(model[21]), 32'd100);

        // Disabled write must not disturb r21
        cycle(32'h02A00000, 10'd6, 1'b0, 5'd21, 32'd7, 1'b0);
        check("hold_r21", regA, 32'd100);

        // Store and a write to the same index being read (same-cycle visibility)
        cycle(32'hAC0A8000, 10'd7, 1'b1, 5'd10, 32'hDEADBEEF, 1'b0);

        // Reset clears registers; reset beats a simultaneous write
        cycle(32'h03E00000, 10'd8, 1'b1, 5'd5, 32'd123, 1'b1);
        cycle(32'h03E50000, 10'd9, 1'b0, 5'd0, 32'd0, 1'b0);
        check("r31_after_rst", regA, 32'd0);
        check("r5_after_rst", regB, 32'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            opTable[4] = 6'($urandom);
            op = opTable[$urandom_range(0, 4)];
            instr = {op, 26'($urandom)};
            cycle(instr, 10'($urandom), 1'($urandom), 5'($urandom), $urandom,
                  ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
